// File: rtl/booth_mult_arbiter.sv
// Round-robin front end for one shared combinational signed multiplier.
// It takes one operation at a time, waits a fixed latency, then holds the product until the consumer accepts it.
module booth_mult_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 16,
  parameter int MULT_LAT = 1,
  parameter int ID_W     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         mult_a,
  output logic [DATA_W-1:0]         mult_b,
  input  logic [2*DATA_W-1:0]       mult_p,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [2*DATA_W-1:0]       rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy
);

  localparam int CNT_W = $clog2(MULT_LAT + 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t          state, state_next;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_found;
  logic [CNT_W-1:0] cnt;
  logic            accept, capture, retire;
  int              idx;

  // The search starts at the pointer, so the requester served last has the lowest priority.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_found && req_valid[ID_W'(idx)]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    accept     = 1'b0;
    capture    = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_id] = 1'b1;
          accept            = 1'b1;
          state_next        = MUL;
        end
      end
      MUL: begin
        if (cnt == CNT_W'(1)) begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (rsp_valid && rsp_ready) begin
          retire     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Operands stay registered until the next accept, so the multiplier input only changes at an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_a    <= '0;
      mult_b    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        mult_a <= req_a[gnt_id*DATA_W +: DATA_W];
        mult_b <= req_b[gnt_id*DATA_W +: DATA_W];
        rsp_id <= gnt_id;
        cnt    <= CNT_W'(MULT_LAT);
        ptr    <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
      if (state == MUL) cnt <= cnt - 1'b1;
      if (capture) begin
        rsp_data  <= mult_p;
        rsp_valid <= 1'b1;
      end
      if (retire) rsp_valid <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Self-checking bench for booth_mult_arbiter. It drives one instance with MULT_LAT=1 and one with MULT_LAT=3.
// A behavioural multiplier and a round-robin/product reference model produce every expected value.
module tb_booth_mult_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk, rst_n;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   mult_a, mult_b;
  logic [2*W-1:0] mult_p, rsp_data;
  logic           rsp_valid, rsp_ready, busy;
  logic [1:0]     rsp_id;

  logic [N-1:0]   rv3, rr3;
  logic [N*W-1:0] ra3, rb3;
  logic [W-1:0]   ma3, mb3;
  logic [2*W-1:0] mp3, rspd3;
  logic           rspv3, rspready3, busy3;
  logic [1:0]     rspid3;

  int           tests = 0;
  int           failures = 0;
  logic [W-1:0] tbA [N];
  logic [W-1:0] tbB [N];
  logic [N-1:0] curMask;
  int           mptr;
  int           gotId;

  booth_mult_arbiter #(.NUM_REQ(N), .DATA_W(W), .MULT_LAT(1), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  booth_mult_arbiter #(.NUM_REQ(N), .DATA_W(W), .MULT_LAT(3), .ID_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv3), .req_a(ra3), .req_b(rb3),
    .req_ready(rr3), .mult_a(ma3), .mult_b(mb3), .mult_p(mp3),
    .rsp_valid(rspv3), .rsp_ready(rspready3), .rsp_data(rspd3), .rsp_id(rspid3), .busy(busy3)
  );

  // Stand-ins for the shared combinational multiplier.
  assign mult_p = $signed(mult_a) * $signed(mult_b);
  assign mp3    = $signed(ma3) * $signed(mb3);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    req_valid = curMask;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = tbA[i];
      req_b[i*W +: W] = tbB[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pickWinner(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] refProduct(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 32'(sa * sb);
  endfunction

  // Requesters must not drop a pending request or change its operands before it is granted.
  logic [N-1:0]   prevPend = '0;
  logic [N*W-1:0] prevA, prevB;
  always @(posedge clk) begin
    if (!rst_n) begin
      prevPend = '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (prevPend[i])
          checkOutput("protocol", 64'({req_valid[i], req_a[i*W +: W], req_b[i*W +: W]}),
                      64'({1'b1, prevA[i*W +: W], prevB[i*W +: W]}));
      prevPend = req_valid & ~req_ready;
      prevA    = req_a;
      prevB    = req_b;
    end
  end

  // mode 0: the winner keeps requesting, 1: the winner drops, 2: random churn of non-pending requesters.
  task automatic runTxn(input string tag, input int stall, input int mode, output int id);
    int g, n;
    logic [31:0] expP;
    logic [W-1:0] ea, eb;
    applyStimulus();
    #1;
    g = pickWinner(curMask, mptr);
    checkOutput({tag, "/ready"}, 64'(req_ready), 64'((g < 0) ? 0 : (1 << g)));
    checkOutput({tag, "/idle"}, 64'(busy), 64'(0));
    id = -1;
    if (g < 0) return;
    ea   = tbA[g];
    eb   = tbB[g];
    expP = refProduct(ea, eb);
    rsp_ready = (stall == 0);
    step();
    mptr = (g + 1) % N;
    checkOutput({tag, "/mult_a"}, 64'(mult_a), 64'(ea));
    checkOutput({tag, "/mult_b"}, 64'(mult_b), 64'(eb));
    checkOutput({tag, "/busy"}, 64'(busy), 64'(1));
    checkOutput({tag, "/ready_mul"}, 64'(req_ready), 64'(0));
    if (mode == 1) begin
      curMask[g] = 1'b0;
      applyStimulus();
    end else if (mode == 2) begin
      for (int i = 0; i < N; i++) begin
        if (i == g || !curMask[i]) begin
          curMask[i] = 1'($urandom_range(1));
          tbA[i] = 16'($urandom);
          tbB[i] = 16'($urandom);
        end
      end
      applyStimulus();
    end
    n = 0;
    do begin
      step();
      n++;
      checkOutput({tag, "/hold"}, 64'({mult_a, mult_b}), 64'({ea, eb}));
    end while (!rsp_valid && n < 20);
    checkOutput({tag, "/latency"}, 64'(n), 64'(1));
    checkOutput({tag, "/rsp_data"}, 64'(rsp_data), 64'(expP));
    checkOutput({tag, "/rsp_id"}, 64'(rsp_id), 64'(g));
    id = int'(rsp_id);
    for (int s = 0; s < stall; s++) begin
      step();
      checkOutput({tag, "/stall"}, 64'({rsp_valid, rsp_data, rsp_id, req_ready, busy}),
                  64'({1'b1, expP, 2'(g), 4'b0000, 1'b1}));
    end
    rsp_ready = 1'b1;
    step();
    checkOutput({tag, "/retire"}, 64'({rsp_valid, busy}), 64'(0));
  endtask

  logic [W-1:0] sgnA [3] = '{16'hFFFD, 16'h8000, 16'h0000};
  logic [W-1:0] sgnB [3] = '{16'h0007, 16'h8000, 16'h0005};
  int           sgnR [3] = '{2, 3, 0};

  initial begin
    int n;
    rst_n = 1'b0; rsp_ready = 1'b1; rspready3 = 1'b1;
    curMask = '0; mptr = 0;
    for (int i = 0; i < N; i++) begin tbA[i] = '0; tbB[i] = '0; end
    applyStimulus();
    rv3 = '0; ra3 = '0; rb3 = '0;
    #1;
    checkOutput("reset/outs", 64'({rsp_valid, rsp_data, rsp_id, mult_a, mult_b, busy, req_ready}), 64'(0));
    checkOutput("reset/outs3", 64'({rspv3, rspd3, rspid3, ma3, mb3, busy3, rr3}), 64'(0));
    step(); step();
    rst_n = 1'b1;
    step();

    // Latency-3 instance: operands held through MUL, product after three edges.
    rv3[2] = 1'b1; ra3[2*W +: W] = 16'd85; rb3[2*W +: W] = 16'd30;
    #1;
    checkOutput("lat3/ready", 64'(rr3), 64'(4'b0100));
    step();
    rv3 = '0;
    checkOutput("lat3/busy", 64'(busy3), 64'(1));
    n = 0;
    do begin
      checkOutput("lat3/hold", 64'({ma3, mb3}), 64'({16'd85, 16'd30}));
      step();
      n++;
    end while (!rspv3 && n < 20);
    checkOutput("lat3/latency", 64'(n), 64'(3));
    checkOutput("lat3/data", 64'(rspd3), 64'(32'd2550));
    checkOutput("lat3/id", 64'(rspid3), 64'(2));
    step();
    checkOutput("lat3/retire", 64'({rspv3, busy3}), 64'(0));

    // Single requester.
    curMask = 4'b0010; tbA[1] = 16'd100; tbB[1] = 16'd12;
    runTxn("single", 0, 1, gotId);

    // Signed corner cases.
    for (int t = 0; t < 3; t++) begin
      curMask = '0;
      curMask[sgnR[t]] = 1'b1;
      tbA[sgnR[t]] = sgnA[t];
      tbB[sgnR[t]] = sgnB[t];
      runTxn("signed", 0, 1, gotId);
    end

    // Backpressure, then a following grant.
    curMask = 4'b1000; tbA[3] = 16'd1234; tbB[3] = 16'hFF00;
    runTxn("backpressure", 5, 1, gotId);
    curMask = 4'b0001; tbA[0] = 16'd9; tbB[0] = 16'd9;
    runTxn("after_bp", 0, 1, gotId);

    // Reset in the middle of an operation.
    curMask = 4'b0001; tbA[0] = 16'd77; tbB[0] = 16'd3;
    applyStimulus();
    step();
    curMask = '0;
    applyStimulus();
    rst_n = 1'b0;
    #1;
    checkOutput("midreset", 64'({rsp_valid, mult_a, mult_b, busy, req_ready}), 64'(0));
    mptr = 0;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("midreset/norsp", 64'({rsp_valid, busy}), 64'(0));
    end

    // All four valid continuously: rotation with wrap.
    curMask = 4'b1111;
    tbA[0] = 16'd90; tbB[0] = 16'd4;
    tbA[1] = 16'd85; tbB[1] = 16'd30;
    tbA[2] = 16'd2;  tbB[2] = 16'd2;
    tbA[3] = 16'd7;  tbB[3] = 16'hFFFF;
    for (int t = 0; t < 8; t++) begin
      runTxn("rr", 0, (t >= 4) ? 1 : 0, gotId);
      checkOutput("rr/order", 64'(gotId), 64'(t % 4));
    end

    // A lone requester re-requesting is served every slot.
    curMask = 4'b0100; tbA[2] = 16'd11; tbB[2] = 16'd13;
    for (int t = 0; t < 3; t++) begin
      runTxn("lone", 0, (t == 2) ? 1 : 0, gotId);
      checkOutput("lone/id", 64'(gotId), 64'(2));
    end

    // Random traffic with churn during MUL/DONE.
    for (int t = 0; t < 40; t++) begin
      if (curMask == '0) begin
        n = $urandom_range(N - 1);
        curMask[n] = 1'b1;
        tbA[n] = 16'($urandom);
        tbB[n] = 16'($urandom);
      end
      runTxn("random", (t % 7 == 3) ? int'($urandom_range(4)) : 0, 2, gotId);
    end
    for (int t = 0; t < N && curMask != '0; t++) runTxn("drain", 0, 1, gotId);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
Shares one combinational 16x16 signed Booth_Multiplier between NUM_REQ requesters in the CNN datapath.
- Round-robin arbitration, registered operand drive to the multiplier, fixed-latency product capture, shared response port with backpressure.
- One multiplication in flight at a time. The block sits between convolution/accumulate requesters and the single multiplier instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 16, operand width; product is 2*DATA_W
MULT_LAT, 1, cycles operands are held stable before the product is sampled (1..4)
ID_W, 2, width of requester index, equals clog2(NUM_REQ)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_a  in  NUM_REQ*DATA_W  packed multiplicands; slice i belongs to requester i
req_b  in  NUM_REQ*DATA_W  packed multipliers; slice i belongs to requester i
req_ready  out  NUM_REQ  one-hot grant/accept, combinational
mult_a  out  DATA_W  registered multiplicand to Booth_Multiplier
mult_b  out  DATA_W  registered multiplier to Booth_Multiplier
mult_p  in  2*DATA_W  product from Booth_Multiplier
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_data  out  2*DATA_W  registered signed product
rsp_id  out  ID_W  index of the requester that owns rsp_data
busy  out  1  high whenever state is not IDLE

Behaviour:
Reset (async, rst_n=0):
- state=IDLE; rsp_valid=0; rsp_data=0; rsp_id=0; mult_a=0; mult_b=0.
- RR pointer=0; latency counter=0.
- Reset mid-operation discards the in-flight op; no response is produced.

FSM states: IDLE, MUL, DONE.

IDLE:
- Winner g = first i with req_valid[i]=1, searching pointer, pointer+1, ... mod NUM_REQ.
- req_ready[g]=1; all other req_ready bits are 0. req_ready is all-zero in MUL/DONE or when no valid is set.
- On a clock edge with req_valid[g]&req_ready[g]:
  - mult_a<=req_a[g]; mult_b<=req_b[g]; rsp_id<=g.
  - counter<=MULT_LAT; pointer<=(g+1) mod NUM_REQ; state<=MUL.

MUL:
- mult_a/mult_b hold.
- Counter decrements each cycle. On the edge where counter==1: rsp_data<=mult_p, rsp_valid<=1, state<=DONE.

DONE:
- rsp_valid, rsp_data and rsp_id are held stable until rsp_ready=1.
- On an edge with rsp_valid&rsp_ready: rsp_valid<=0, state<=IDLE.
- No new request is accepted in the same cycle.

Latency and throughput:
- Accept edge E0; rsp_valid is first high after edge E0+MULT_LAT.
- Minimum period between accepts is MULT_LAT+2 cycles, with rsp_ready tied high.

Arithmetic:
- Two's-complement signed operands and product; no truncation or saturation.
- -32768*-32768 = 32'h4000_0000.

Requester protocol:
- Once req_valid[i] is raised, it and its operands stay stable until req_ready[i].
- Dropping req_valid early is a protocol violation; the bench asserts on it.

Simultaneous and boundary cases:
- All requesters valid: strict rotation 0,1,2,3,0,...
- Pointer wraps from NUM_REQ-1 to 0.
- A single requester re-requesting is granted every slot; others get no starvation beyond NUM_REQ-1 grants.
- req_valid changes during MUL/DONE do not affect the current op.
- rsp_ready held low stalls indefinitely in DONE.

busy = (state != IDLE).

Test Plan:
- Reset: drive rst_n=0 mid-MUL -> next cycle state IDLE, rsp_valid=0, mult_a=mult_b=0, busy=0; no response later.
- Single requester: req 1 with a=100, b=12, MULT_LAT=1, rsp_ready=1 -> req_ready=4'b0010 in accept cycle; rsp_valid high exactly 1 cycle after accept edge; rsp_data=1200, rsp_id=1.
- Signed values: (-3,7) -> 32'hFFFF_FFEB; (-32768,-32768) -> 32'h4000_0000; (0,5) -> 0.
- Round robin: all four valid continuously with distinct operands (90*4, 85*30, 2*2, 7*-1) -> grant order 0,1,2,3,0; responses 360, 2550, 4, -7 with matching rsp_id; pointer wraps.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data/rsp_id stable, req_ready all-zero, busy=1; rsp_ready=1 -> IDLE next cycle, next grant follows.
- MULT_LAT=3 build: accept at E0 -> rsp_valid rises after E0+3; mult_a/b stable through MUL; product 85*30=2550.
